ascon_dec_fsm: RTL

ASCON_DEC_FSM -- requirements
Module: ascon_dec_fsm

---
 rtl/ascon_pack.sv | 25 ++
 rtl/round_counter.sv | 28 ++
 rtl/ascon_dec_fsm.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ascon_pack.sv
// Shared types and round constants for the Ascon decryption controller.
package ascon_pack;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_INIT       = 4'd1,
        S_WAIT_AD    = 4'd2,
        S_AD         = 4'd3,
        S_WAIT_CT    = 4'd4,
        S_CT         = 4'd5,
        S_WAIT_FINAL = 4'd6,
        S_FINAL      = 4'd7,
        S_CHECK      = 4'd8,
        S_DONE       = 4'd9
    } dec_state_t;

    localparam logic [3:0] ROUND_P12_START = 4'd0;
    localparam logic [3:0] ROUND_P6_START  = 4'd6;
    localparam logic [3:0] ROUND_LAST      = 4'd11;

    function automatic logic is_perm(dec_state_t s);
        return (s == S_INIT) || (s == S_AD) || (s == S_CT) || (s == S_FINAL);
    endfunction

endpackage

// File: rtl/round_counter.sv
// 4-bit permutation round counter with synchronous load and increment.
module round_counter (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       en_i,
    output logic [3:0] count_o
);

    logic [3:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i)
            count_d = load_val_i;
        else if (en_i)
            count_d = count_q + 4'd1;
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) count_q <= 4'd0;
        else           count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/ascon_dec_fsm.sv
// Ascon decryption control: sequences init, AD, ciphertext and final
// permutations, drives datapath strobes and reports tag verification.
module ascon_dec_fsm
    import ascon_pack::*;
#(
    parameter int NB_CT_P6 = 2
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       data_valid_i,
    input  logic       tag_match_i,
    output logic [3:0] round_o,
    output logic       en_reg_state_o,
    output logic       sel_init_o,
    output logic       input_mode_o,
    output logic       en_xor_key_o,
    output logic       en_xor_key_final_o,
    output logic       en_xor_data_o,
    output logic       en_xor_lsb_o,
    output logic       en_replace_data_o,
    output logic       en_plain_o,
    output logic       en_tag_o,
    output logic       plain_valid_o,
    output logic       busy_o,
    output logic       end_o,
    output logic       auth_ok_o,
    output logic       auth_fail_o
);

    localparam logic [3:0] NB_L = 4'(NB_CT_P6);

    dec_state_t state_q, state_d;
    logic [3:0] blk_cnt_q, blk_cnt_d;
    logic       auth_ok_q, auth_ok_d;
    logic       auth_fail_q, auth_fail_d;
    logic       plain_valid_q, plain_valid_d;
    logic       cnt_load, cnt_en, first_rnd, last_rnd;
    logic [3:0] cnt_load_val;

    round_counter u_round_counter (
        .clock_i    (clock_i),
        .resetb_i   (resetb_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .en_i       (cnt_en),
        .count_o    (round_o)
    );

    assign last_rnd  = (round_o == ROUND_LAST);
    assign first_rnd = (round_o == ROUND_P12_START);

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q       <= S_IDLE;
            blk_cnt_q     <= 4'd0;
            auth_ok_q     <= 1'b0;
            auth_fail_q   <= 1'b0;
            plain_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            blk_cnt_q     <= blk_cnt_d;
            auth_ok_q     <= auth_ok_d;
            auth_fail_q   <= auth_fail_d;
            plain_valid_q <= plain_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        blk_cnt_d   = blk_cnt_q;
        auth_ok_d   = auth_ok_q;
        auth_fail_d = auth_fail_q;
        case (state_q)
            S_IDLE: if (start_i) begin
                state_d     = S_INIT;
                blk_cnt_d   = 4'd0;
                auth_ok_d   = 1'b0;
                auth_fail_d = 1'b0;
            end
            S_INIT:       if (last_rnd) state_d = S_WAIT_AD;
            S_WAIT_AD:    if (data_valid_i) state_d = S_AD;
            S_AD:         if (last_rnd) state_d = S_WAIT_CT;
            S_WAIT_CT:    if (data_valid_i) state_d = S_CT;
            S_CT: if (last_rnd) begin
                blk_cnt_d = blk_cnt_q + 4'd1;
                state_d   = (blk_cnt_d == NB_L) ? S_WAIT_FINAL : S_WAIT_CT;
            end
            S_WAIT_FINAL: if (data_valid_i) state_d = S_FINAL;
            S_FINAL:      if (last_rnd) state_d = S_CHECK;
            S_CHECK: begin
                auth_ok_d   = tag_match_i;
                auth_fail_d = !tag_match_i;
                state_d     = S_DONE;
            end
            S_DONE:       state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // The counter reloads on entry to a permutation; the reload wins over increment.
    always_comb begin
        cnt_load     = (state_d != state_q) && is_perm(state_d);
        cnt_load_val = ((state_d == S_INIT) || (state_d == S_FINAL)) ? ROUND_P12_START
                                                                     : ROUND_P6_START;
        cnt_en       = is_perm(state_q);
    end

    always_comb begin
        en_reg_state_o     = 1'b0;
        sel_init_o         = 1'b0;
        input_mode_o       = 1'b1;
        busy_o             = 1'b1;
        en_xor_key_o       = 1'b0;
        en_xor_key_final_o = 1'b0;
        en_xor_data_o      = 1'b0;
        en_xor_lsb_o       = 1'b0;
        en_replace_data_o  = 1'b0;
        en_plain_o         = 1'b0;
        en_tag_o           = 1'b0;
        end_o              = 1'b0;
        case (state_q)
            S_IDLE: begin
                input_mode_o = 1'b0;
                busy_o       = 1'b0;
            end
            S_INIT: begin
                en_reg_state_o = 1'b1;
                sel_init_o     = first_rnd;
                input_mode_o   = !first_rnd;
                en_xor_key_o   = last_rnd;
            end
            S_AD: begin
                en_reg_state_o = 1'b1;
                en_xor_data_o  = (round_o == ROUND_P6_START);
                en_xor_lsb_o   = last_rnd;
            end
            S_CT: begin
                en_reg_state_o    = 1'b1;
                en_plain_o        = (round_o == ROUND_P6_START);
                en_replace_data_o = (round_o == ROUND_P6_START);
            end
            S_FINAL: begin
                en_reg_state_o     = 1'b1;
                en_plain_o         = first_rnd;
                en_replace_data_o  = first_rnd;
                en_xor_key_final_o = first_rnd;
                en_xor_key_o       = last_rnd;
                en_tag_o           = last_rnd;
            end
            S_WAIT_AD, S_WAIT_CT, S_WAIT_FINAL, S_CHECK: ;
            S_DONE:  end_o = 1'b1;
            default: begin
                input_mode_o = 1'b0;
                busy_o       = 1'b0;
            end
        endcase
    end

    assign plain_valid_d = en_plain_o;
    assign plain_valid_o = plain_valid_q;
    assign auth_ok_o     = auth_ok_q;
    assign auth_fail_o   = auth_fail_q;

endmodule
